// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data RAM arbiter
// and the video scan-out reader.
package data_mem_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_W     = 4;

  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VID
  } owner_t;

  typedef struct packed {
    logic cpu;
    logic vid;
    logic force_vid;
  } gnt_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between CPU, video reader, arbiter and RAM.
// arb: arbiter side; env: requesters plus RAM side.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport arb (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_gnt,
    output cpu_rvalid,
    output cpu_rdata,
    input  vid_req,
    input  vid_addr,
    output vid_gnt,
    output vid_rvalid,
    output vid_rdata,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport env (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_gnt,
    input  cpu_rvalid,
    input  cpu_rdata,
    output vid_req,
    output vid_addr,
    input  vid_gnt,
    input  vid_rvalid,
    input  vid_rdata,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_arbiter_starve_cnt.sv
// Saturating event counter with a threshold compare; used for
// the video wait counter and the optional perf counters.
module arb_starve_cnt #(
  parameter int W     = 4,
  parameter int LIMIT = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt_q,
  output logic         hit
);

  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (32'(cnt_q) >= 32'(LIMIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// CPU/video arbiter for the single-port data RAM.
// Optional ARB_PERF_CNT_EN adds video stall/force counters.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            resetN,
  data_mem_arbiter_if.arb bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]     perf_vid_stall,
  output logic [15:0]     perf_force
`endif
);

  gnt_t              gnt;
  logic              hit;
  logic              vid_wait;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] rdata;
  owner_t            owner_q;
  owner_t            owner_d;

  arb_starve_cnt #(
    .W     (WAIT_W),
    .LIMIT (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .resetN (resetN),
    .inc    (vid_wait),
    .clr    (gnt.vid),
    .cnt_q  (wait_cnt),
    .hit    (hit)
  );

  // Grants are gated by resetN so nothing reaches the RAM in reset.
  always_comb begin
    gnt           = '0;
    gnt.force_vid = bus.vid_req & hit;
    gnt.vid       = resetN & bus.vid_req
                  & (~bus.cpu_req | gnt.force_vid);
    gnt.cpu       = resetN & bus.cpu_req
                  & ~gnt.vid;
  end

  assign vid_wait = bus.vid_req & ~gnt.vid;

  assign addr_sel = gnt.vid ? bus.vid_addr
                            : bus.cpu_addr;

  assign bus.cpu_gnt   = gnt.cpu;
  assign bus.vid_gnt   = gnt.vid;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_we    = gnt.cpu & bus.cpu_we;
  assign bus.mem_wdata = bus.cpu_wdata;

  always_comb begin
    owner_d = OWN_NONE;
    unique case (1'b1)
      gnt.vid: owner_d = OWN_VID;
      gnt.cpu & ~bus.cpu_we: owner_d = OWN_CPU;
      default: owner_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign rdata = bus.mem_rdata;

  assign bus.cpu_rvalid = (owner_q == OWN_CPU);
  assign bus.vid_rvalid = (owner_q == OWN_VID);
  assign bus.cpu_rdata  = rdata;
  assign bus.vid_rdata  = rdata;

`ifdef ARB_PERF_CNT_EN
  logic stall_full;
  logic force_full;
  logic force_evt;

  assign force_evt = gnt.vid & gnt.force_vid;

  arb_starve_cnt #(
    .W     (16),
    .LIMIT (16'hFFFF)
  ) u_perf_stall (
    .clk    (clk),
    .resetN (resetN),
    .inc    (vid_wait),
    .clr    (1'b0),
    .cnt_q  (perf_vid_stall),
    .hit    (stall_full)
  );

  arb_starve_cnt #(
    .W     (16),
    .LIMIT (16'hFFFF)
  ) u_perf_force (
    .clk    (clk),
    .resetN (resetN),
    .inc    (force_evt),
    .clr    (1'b0),
    .cnt_q  (perf_force),
    .hit    (force_full)
  );
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed
// scenarios plus randomized traffic against a behavioural model.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_vid_stall;
  logic [15:0] perf_force;
`endif

  data_mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .bus            (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_vid_stall (perf_vid_stall),
    .perf_force     (perf_force)
`endif
  );

  // RAM behind the arbiter, driven only by the DUT mem bus
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Model state
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int  m_wait = 0;
  int  m_stall = 0;
  int  m_force = 0;
  bit  p_cpu = 0;
  bit  p_vid = 0;
  logic [DW-1:0] p_cpu_d = '0;
  logic [DW-1:0] p_vid_d = '0;
  bit  got_cpu = 0;
  bit  got_vid = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reset drops any read in flight and restarts the counters
  initial forever begin
    @(negedge resetN);
    p_cpu = 0;
    p_vid = 0;
    m_wait = 0;
    m_stall = 0;
    m_force = 0;
  end

  // Compare process: every negedge, DUT vs model
  initial forever begin
    bit frc, eg_v, eg_c, wr;
    @(negedge clk);
    if (!resetN) begin
      chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
      chk("rst_vid_gnt", 32'(bus.vid_gnt), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_cpu_rv", 32'(bus.cpu_rvalid), 0);
      chk("rst_vid_rv", 32'(bus.vid_rvalid), 0);
      p_cpu = 0;
      p_vid = 0;
      got_cpu = 0;
      got_vid = 0;
    end else begin
      frc  = bus.vid_req && (m_wait >= MW);
      eg_v = bus.vid_req && (!bus.cpu_req || frc);
      eg_c = bus.cpu_req && !eg_v;
      wr   = eg_c && bus.cpu_we;
      chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(eg_c));
      chk("vid_gnt", 32'(bus.vid_gnt), 32'(eg_v));
      chk("mem_we", 32'(bus.mem_we), 32'(wr));
      chk("mem_addr", 32'(bus.mem_addr),
          eg_v ? 32'(bus.vid_addr) : 32'(bus.cpu_addr));
      if (wr)
        chk("mem_wdata", 32'(bus.mem_wdata),
            32'(bus.cpu_wdata));
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(p_cpu));
      chk("vid_rvalid", 32'(bus.vid_rvalid), 32'(p_vid));
      if (p_cpu)
        chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(p_cpu_d));
      if (p_vid)
        chk("vid_rdata", 32'(bus.vid_rdata), 32'(p_vid_d));
`ifdef ARB_PERF_CNT_EN
      chk("perf_stall", 32'(perf_vid_stall), 32'(m_stall));
      chk("perf_force", 32'(perf_force), 32'(m_force));
`endif
      if (bus.vid_req) begin
        if (eg_v) begin
          if (frc && m_force < 65535) m_force++;
          m_wait = 0;
        end else begin
          if (m_wait < 15) m_wait++;
          if (m_stall < 65535) m_stall++;
        end
      end
      p_cpu = eg_c && !bus.cpu_we;
      p_cpu_d = shadow[bus.cpu_addr];
      p_vid = eg_v;
      p_vid_d = shadow[bus.vid_addr];
      if (wr) shadow[bus.cpu_addr] = bus.cpu_wdata;
      got_cpu = eg_c;
      got_vid = eg_v;
    end
  end

  task automatic drive(input bit creq, input bit cwe,
                       input logic [14:0] caddr,
                       input logic [15:0] cwd,
                       input bit vreq,
                       input logic [14:0] vaddr);
    @(posedge clk);
    #1;
    bus.cpu_req = creq;
    bus.cpu_we = cwe;
    bus.cpu_addr = caddr;
    bus.cpu_wdata = cwd;
    bus.vid_req = vreq;
    bus.vid_addr = vaddr;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 16'(i * 7 + 3);
      shadow[i] = 16'(i * 7 + 3);
    end
    ram[15'h0010] = 16'h1234;
    shadow[15'h0010] = 16'h1234;
    bus.cpu_req = 0;
    bus.cpu_we = 0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.vid_req = 0;
    bus.vid_addr = '0;

    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    settle();
    chk("lit_idle_cpu_gnt", 32'(bus.cpu_gnt), 0);
    chk("lit_idle_vid_gnt", 32'(bus.vid_gnt), 0);
    chk("lit_idle_cpu_rv", 32'(bus.cpu_rvalid), 0);
    chk("lit_idle_vid_rv", 32'(bus.vid_rvalid), 0);
    chk("lit_idle_mem_we", 32'(bus.mem_we), 0);

    drive(1, 0, 15'h0010, 16'h0, 0, 15'h0);
    settle();
    chk("lit_rd_gnt", 32'(bus.cpu_gnt), 1);
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    settle();
    chk("lit_rd_rv", 32'(bus.cpu_rvalid), 1);
    chk("lit_rd_data", 32'(bus.cpu_rdata), 32'h1234);
    chk("lit_rd_vid_rv", 32'(bus.vid_rvalid), 0);

    drive(1, 1, SCREEN_BASE, 16'hBEEF, 0, 15'h0);
    settle();
    chk("lit_wr_gnt", 32'(bus.cpu_gnt), 1);
    chk("lit_wr_we", 32'(bus.mem_we), 1);
    drive(0, 0, 15'h0, 16'h0, 1, SCREEN_BASE);
    settle();
    chk("lit_vrd_gnt", 32'(bus.vid_gnt), 1);
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    settle();
    chk("lit_vrd_rv", 32'(bus.vid_rvalid), 1);
    chk("lit_vrd_data", 32'(bus.vid_rdata), 32'hBEEF);

    // Starvation run from a fresh reset
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    bus.cpu_req = 1;
    bus.cpu_we = 0;
    bus.cpu_addr = 15'h0010;
    bus.vid_req = 1;
    bus.vid_addr = 15'h4001;
    for (int i = 0; i < 10; i++) begin
      settle();
      hit = (i == 4) || (i == 9);
      chk($sformatf("lit_starve_vg%0d", i),
          32'(bus.vid_gnt), 32'(hit));
      chk($sformatf("lit_starve_cg%0d", i),
          32'(bus.cpu_gnt), 32'(!hit));
      if (i == 5)
        chk("lit_wait_cnt5", 32'(dut.wait_cnt), 0);
    end
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    settle();
`ifdef ARB_PERF_CNT_EN
    chk("lit_perf_stall", 32'(perf_vid_stall), 8);
    chk("lit_perf_force", 32'(perf_force), 2);
`endif

    // Reset between a CPU read grant and its return
    drive(1, 0, 15'h0020, 16'h0, 0, 15'h0);
    settle();
    chk("lit_mid_gnt", 32'(bus.cpu_gnt), 1);
    resetN = 1'b0;
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    settle();
    chk("lit_mid_rv_rst", 32'(bus.cpu_rvalid), 0);
    @(posedge clk);
    #1 resetN = 1'b1;
    settle();
    chk("lit_mid_rv_rel", 32'(bus.cpu_rvalid), 0);
    chk("lit_mid_owner", 32'(dut.owner_q), 32'(OWN_NONE));

    // Randomized traffic honouring hold-until-grant
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if (resetN == 1'b0) begin
        resetN = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        resetN = 1'b0;
        bus.cpu_req = 0;
        bus.vid_req = 0;
      end else begin
        if (!bus.cpu_req || got_cpu) begin
          int sel;
          sel = int'($urandom_range(0, 2));
          bus.cpu_req = ($urandom_range(0, 3) != 0);
          bus.cpu_we = $urandom_range(0, 1) != 0;
          bus.cpu_wdata = 16'($urandom);
          bus.cpu_addr = 15'((sel == 0 ? 15'h0010 :
                              sel == 1 ? SCREEN_BASE :
                              KBD_ADDR)
                             + $urandom_range(0, 15));
        end
        if (!bus.vid_req || got_vid) begin
          bus.vid_req = ($urandom_range(0, 2) != 0);
          bus.vid_addr = 15'(SCREEN_BASE
                             + $urandom_range(0, 15));
        end
      end
    end

    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    settle();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: the CPU data port and the video scan-out reader.
- The CPU port carries a 15-bit address, a write enable and 16-bit write data. The video reader issues read-only requests into the screen region.
- Grants at most one access per cycle and routes the 1-cycle-latency read data back to the owner.
- The CPU has fixed priority. A starvation counter forces a video grant after a bounded wait.

Parameters:
- ADDR_W, 15, address width of both ports and the RAM.
- DATA_W, 16, data width.
- MAX_WAIT, 4, number of consecutive cycles video may be denied before it is forced to win; legal range 1..15.

Ports:
- clk  input  1  clock.
- resetN  input  1  reset; asynchronous, active-low.
- cpu_req  input  1  CPU access request this cycle.
- cpu_we  input  1  CPU write (1) or read (0).
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_gnt  output  1  CPU access issued to the RAM this cycle (combinational).
- cpu_rvalid  output  1  CPU read data valid (registered).
- cpu_rdata  output  DATA_W  CPU read data.
- vid_req  input  1  video read request; held until granted.
- vid_addr  input  ADDR_W  video address; stable while vid_req is high.
- vid_gnt  output  1  video access issued this cycle (combinational).
- vid_rvalid  output  1  video read data valid (registered).
- vid_rdata  output  DATA_W  video read data.
- mem_addr  output  ADDR_W  RAM address.
- mem_we  output  1  RAM write enable.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data, valid 1 cycle after the address.

Behaviour:
- Reset (asynchronous, resetN low):
  - wait_cnt=0, owner_q=NONE, cpu_rvalid=0, vid_rvalid=0.
  - cpu_gnt and vid_gnt are forced 0 while resetN is low.
  - mem_we=0; mem_addr and mem_wdata are don't-care.
- Arbitration (combinational, each cycle):
  - force = vid_req && (wait_cnt >= MAX_WAIT).
  - vid_gnt = vid_req && (!cpu_req || force).
  - cpu_gnt = cpu_req && !vid_gnt.
  - The CPU must hold its request until cpu_gnt. Its stall phase absorbs the loss.
- RAM drive:
  - mem_addr is the granted requester's address. With no grant, mem_addr = cpu_addr.
  - mem_we = cpu_gnt && cpu_we. Video never writes.
  - mem_wdata = cpu_wdata.
- wait_cnt (saturates at 15):
  - Resets to 0 on vid_gnt.
  - Increments when vid_req is high and vid_gnt is low.
  - Holds when vid_req is low.
- owner_q FSM, states NONE / CPU / VID, next state from this cycle's grant:
  - CPU when cpu_gnt && !cpu_we.
  - VID when vid_gnt.
  - NONE otherwise, including CPU writes.
- Read return:
  - cpu_rvalid = (owner_q==CPU); vid_rvalid = (owner_q==VID).
  - Both rdata outputs present mem_rdata. Only the matching rvalid is asserted.
  - Latency is exactly 1 cycle from grant to rvalid. Back-to-back grants are allowed every cycle.
- Boundary cases:
  - Simultaneous requests without force: CPU wins.
  - Simultaneous requests with force: video wins once, then the counter restarts.
  - A CPU write and a later video read of the same address are ordered by grant cycle. The read sees the written value.
  - Reset mid-read: the in-flight rvalid is dropped. No rvalid is ever issued for that grant.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds output perf_vid_stall [15:0]:
  - Counts cycles with vid_req && !vid_gnt.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Also adds output perf_force [15:0]: counts forced video grants, saturating, cleared by reset.
- When not defined, neither port nor counter exists. Arbitration behaviour is identical either way.

Decomposition:
- Package data_mem_pkg holds:
  - typedef enum owner_t {OWN_NONE, OWN_CPU, OWN_VID};
  - localparams for the default ADDR_W and DATA_W;
  - SCREEN_BASE = 15'h4000 and KBD_ADDR = 15'h6000, shared with the video reader.
- One natural sub-module: arb_starve_cnt. It holds the saturating wait counter and the force compare, and is reused by the optional perf counters.

Test Plan:
- Reset release, no requests:
  - all grants and rvalids are 0; mem_we=0.
- CPU read only: cpu_req=1, cpu_we=0, cpu_addr=0x0010, RAM[0x10]=0x1234.
  - cpu_gnt=1 the same cycle.
  - next cycle cpu_rvalid=1 and cpu_rdata=0x1234; vid_rvalid=0.
- CPU write then video read: CPU writes 0xBEEF to 0x4000, then vid_req with vid_addr=0x4000 while cpu_req=0.
  - vid_gnt=1.
  - one cycle later vid_rvalid=1 and vid_rdata=0xBEEF.
- Starvation with MAX_WAIT=4: cpu_req held 1 every cycle, vid_req=1 from cycle 0.
  - vid_gnt=0 on cycles 0-3 and vid_gnt=1 on cycle 4.
  - cpu_gnt=0 on cycle 4 only; wait_cnt=0 on cycle 5.
- Reset mid-read: grant a CPU read, then drop resetN before the next edge.
  - cpu_rvalid stays 0; owner_q=NONE after release.
- With ARB_PERF_CNT_EN, repeat the starvation scenario for 10 cycles.
  - perf_vid_stall=8 and perf_force=2.
  - A build without the macro shows identical grant traces.
